// File: rtl/br_multiport_if.sv
// br_multiport_if: bundles the write-back lanes, read ports and status of br_multiport.
// Latency: none; this is a plain signal bundle.
// Backpressure: none; busy is the only flow indication (writes dropped while it is high).
// Ports: master drives clear_req/write lanes/read addresses; slave drives read data, busy, wr_conflict.
interface br_multiport_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              clear_req;
    logic              we0;
    logic [ADDR_W-1:0] aw0;
    logic [DATA_W-1:0] dw0;
    logic              we1;
    logic [ADDR_W-1:0] aw1;
    logic [DATA_W-1:0] dw1;
    logic [ADDR_W-1:0] ar1;
    logic [ADDR_W-1:0] ar2;
    logic [DATA_W-1:0] dr1;
    logic [DATA_W-1:0] dr2;
    logic              busy;
    logic              wr_conflict;

    modport master (
        output clear_req, we0, aw0, dw0, we1, aw1, dw1, ar1, ar2,
        input  dr1, dr2, busy, wr_conflict
    );

    modport slave (
        input  clear_req, we0, aw0, dw0, we1, aw1, dw1, ar1, ar2,
        output dr1, dr2, busy, wr_conflict
    );
endinterface

// File: rtl/br_multiport.sv
// br_multiport: two-write/two-read register bank with hard-wired zero entry, write bypass and clear sweep.
// Latency: reads are combinational (0 cycles); writes land in the array on the next rising edge.
// Backpressure: none; while busy (clear sweep) writes are discarded and both read ports return 0.
// Ports: clk, rst_n (async active-low), bus (slave modport of br_multiport_if: write lanes 0/1,
//        read ports 1/2, clear_req, busy, wr_conflict).
module br_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    br_multiport_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;
    logic              r_wr_conflict;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_busy;
    logic w_eff0;
    logic w_eff1;
    logic w_commit;
    logic w_conflict_nxt;

    assign w_busy = (r_state == S_CLEAR);

    // A lane aimed at the hard-wired zero entry is not effective: it neither stores nor bypasses.
    assign w_eff0 = bus.we0 && !((ZERO_REG != 0) && (bus.aw0 == '0));
    assign w_eff1 = bus.we1 && !((ZERO_REG != 0) && (bus.aw1 == '0));

    // Writes commit only in IDLE, and not on the edge that launches a clear sweep.
    assign w_commit       = !w_busy && !bus.clear_req;
    assign w_conflict_nxt = w_commit && w_eff0 && w_eff1 && (bus.aw0 == bus.aw1);

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            S_CLEAR: begin
                // Counter wraps to 0 on the edge that clears the last entry.
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (&r_clr_cnt) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.clear_req) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = S_CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_CLEAR;
            r_clr_cnt     <= '0;
            r_wr_conflict <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_clr_cnt     <= w_clr_cnt_nxt;
            r_wr_conflict <= w_conflict_nxt;
        end
    end

    // Array has no reset; the sweep zeroes it. Held off while rst_n is low so reset leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_busy) begin
                r_mem[r_clr_cnt] <= '0;
            end else if (w_commit) begin
                if (w_eff0) begin
                    r_mem[bus.aw0] <= bus.dw0;
                end
                // Issued after lane 0 so lane 1 wins when both hit the same entry.
                if (w_eff1) begin
                    r_mem[bus.aw1] <= bus.dw1;
                end
            end
        end
    end

    // Read mux: zero (busy / zero entry) beats lane-1 bypass, which beats lane-0 bypass, then the array.
    function automatic logic [DATA_W-1:0] rd_sel(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              busy,
        input logic              eff0,
        input logic [ADDR_W-1:0] aw0,
        input logic [DATA_W-1:0] dw0,
        input logic              eff1,
        input logic [ADDR_W-1:0] aw1,
        input logic [DATA_W-1:0] dw1
    );
        logic [DATA_W-1:0] d;
        d = stored;
        if ((BYPASS != 0) && eff0 && (aw0 == a)) begin
            d = dw0;
        end
        if ((BYPASS != 0) && eff1 && (aw1 == a)) begin
            d = dw1;
        end
        if (busy || ((ZERO_REG != 0) && (a == '0))) begin
            d = '0;
        end
        return d;
    endfunction

    assign bus.dr1 = rd_sel(bus.ar1, r_mem[bus.ar1], w_busy, w_eff0, bus.aw0, bus.dw0,
                            w_eff1, bus.aw1, bus.dw1);
    assign bus.dr2 = rd_sel(bus.ar2, r_mem[bus.ar2], w_busy, w_eff0, bus.aw0, bus.dw0,
                            w_eff1, bus.aw1, bus.dw1);

    assign bus.busy        = w_busy;
    assign bus.wr_conflict = r_wr_conflict;
endmodule

// File: tb/tb_br_multiport.sv
// tb_br_multiport: scoreboard bench for br_multiport (BYPASS=1 main instance, BYPASS=0 shadow instance).
// Latency: expectations pushed just after a rising edge are checked at the following falling edge.
// Backpressure: none; sweeps are bounded by a 100-edge budget.
module tb_br_multiport;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    typedef enum int {K_DR1, K_DR2, K_BUSY, K_CONF, K_NB_DR1, K_CNT} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    br_multiport_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
    br_multiport_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

    br_multiport #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a)
    );

    br_multiport #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b)
    );

    exp_t q[$];
    int   n_pass   = 0;
    int   n_total  = 0;
    int   meas_cnt = 0;

    // Monitor: drains the scoreboard at every falling edge, comparing against live DUT outputs.
    exp_t        m_e;
    logic [31:0] m_act;
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                m_e = q.pop_front();
                case (m_e.kind)
                    K_DR1:    m_act = bus_a.dr1;
                    K_DR2:    m_act = bus_a.dr2;
                    K_BUSY:   m_act = {31'd0, bus_a.busy};
                    K_CONF:   m_act = {31'd0, bus_a.wr_conflict};
                    K_NB_DR1: m_act = bus_b.dr1;
                    default:  m_act = meas_cnt;
                endcase
                n_total++;
                if (m_act === m_e.exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got 0x%08h expected 0x%08h", m_e.name, m_act, m_e.exp);
                end
            end
        end
    end

    task automatic push_exp(input kind_t k, input logic [31:0] v, input string nm);
        exp_t e;
        e.kind = k;
        e.exp  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic cr, input logic we0, input logic [AW-1:0] aw0,
                          input logic [DW-1:0] dw0, input logic we1, input logic [AW-1:0] aw1,
                          input logic [DW-1:0] dw1, input logic [AW-1:0] ar1,
                          input logic [AW-1:0] ar2);
        bus_a.clear_req = cr;  bus_b.clear_req = cr;
        bus_a.we0 = we0;       bus_b.we0 = we0;
        bus_a.aw0 = aw0;       bus_b.aw0 = aw0;
        bus_a.dw0 = dw0;       bus_b.dw0 = dw0;
        bus_a.we1 = we1;       bus_b.we1 = we1;
        bus_a.aw1 = aw1;       bus_b.aw1 = aw1;
        bus_a.dw1 = dw1;       bus_b.dw1 = dw1;
        bus_a.ar1 = ar1;       bus_b.ar1 = ar1;
        bus_a.ar2 = ar2;       bus_b.ar2 = ar2;
    endtask

    task automatic wr_off();
        bus_a.clear_req = 1'b0; bus_b.clear_req = 1'b0;
        bus_a.we0 = 1'b0;       bus_b.we0 = 1'b0;
        bus_a.we1 = 1'b0;       bus_b.we1 = 1'b0;
    endtask

    // Counts rising edges until busy drops; optionally pokes a write and a clear_req mid-sweep.
    task automatic sweep(input int exp_edges, input bit pokes, input string tag);
        int n = 0;
        do begin
            step();
            n++;
            if (n == 1) wr_off();
            if (pokes && n == 20) begin
                set_in(1'b1, 1'b1, 5'd2, 32'h66666666, 1'b0, 5'd0, '0, 5'd2, 5'd2);
                push_exp(K_DR1, 32'h0, "sweep_read_zero");
                push_exp(K_CONF, 32'h0, "sweep_conf_zero");
            end
            if (pokes && n == 21) wr_off();
        end while (bus_a.busy && n < 100);
        meas_cnt = n;
        push_exp(K_CNT, exp_edges, tag);
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 5'(i), 5'(DEPTH - 1 - i));
            push_exp(K_DR1, 32'h0, tag);
            push_exp(K_DR2, 32'h0, tag);
            step();
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        set_in(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd3, 5'd7);
        step();
        step();
        push_exp(K_BUSY, 32'h1, "rst_busy");
        push_exp(K_CONF, 32'h0, "rst_conf");
        push_exp(K_DR1, 32'h0, "rst_dr1");
        step();

        // Reset-release sweep: 32 busy edges, then everything reads 0
        rst_n = 1'b1;
        sweep(DEPTH, 1'b0, "rst_sweep_edges");
        n_total++;
        if (bus_a.busy === 1'b0) begin
            n_pass++;
        end else begin
            $display("FAIL rst_sweep_idle: busy still high");
        end
        n_total++;
        if (bus_b.busy === 1'b0) begin
            n_pass++;
        end else begin
            $display("FAIL nb_rst_sweep_idle: busy still high");
        end
        read_all_zero("rst_read_zero");

        // Dual write to different addresses
        set_in(1'b0, 1'b1, 5'd3, 32'h11111111, 1'b1, 5'd7, 32'h22222222, 5'd0, 5'd0);
        step();
        wr_off();
        bus_a.ar1 = 5'd3; bus_b.ar1 = 5'd3;
        bus_a.ar2 = 5'd7; bus_b.ar2 = 5'd7;
        push_exp(K_DR1, 32'h11111111, "dual_dr1");
        push_exp(K_DR2, 32'h22222222, "dual_dr2");
        push_exp(K_CONF, 32'h0, "dual_noconf");
        push_exp(K_NB_DR1, 32'h11111111, "nb_dual_dr1");
        #1;
        n_total++;
        if (bus_b.dr2 === 32'h22222222) begin
            n_pass++;
        end else begin
            $display("FAIL nb_dual_dr2: got 0x%08h expected 0x22222222", bus_b.dr2);
        end
        step();

        // Same-address conflict: lane 1 wins, one-cycle wr_conflict pulse
        set_in(1'b0, 1'b1, 5'd5, 32'hAAAA0000, 1'b1, 5'd5, 32'h0000BBBB, 5'd5, 5'd7);
        push_exp(K_DR1, 32'h0000BBBB, "conf_bypass_lane1");
        step();
        wr_off();
        push_exp(K_DR1, 32'h0000BBBB, "conf_stored");
        push_exp(K_CONF, 32'h1, "conf_pulse");
        step();
        push_exp(K_CONF, 32'h0, "conf_pulse_end");
        step();

        // Bypass (main) versus no bypass (shadow instance)
        set_in(1'b0, 1'b1, 5'd9, 32'hDEADBEEF, 1'b0, 5'd0, '0, 5'd9, 5'd3);
        push_exp(K_DR1, 32'hDEADBEEF, "bypass_same_cycle");
        push_exp(K_NB_DR1, 32'h0, "nobypass_old_value");
        push_exp(K_DR2, 32'h11111111, "bypass_other_port");
        step();
        wr_off();
        push_exp(K_DR1, 32'hDEADBEEF, "bypass_stored");
        push_exp(K_NB_DR1, 32'hDEADBEEF, "nobypass_stored");
        step();

        // Zero entry: writes discarded, no bypass, no conflict
        set_in(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        push_exp(K_DR1, 32'h0, "zero_no_bypass");
        step();
        wr_off();
        push_exp(K_DR1, 32'h0, "zero_read");
        push_exp(K_CONF, 32'h0, "zero_noconf");
        step();

        // clear_req sweep with a dropped write; mid-sweep write and clear_req are ignored
        set_in(1'b1, 1'b1, 5'd4, 32'h55555555, 1'b0, 5'd0, '0, 5'd4, 5'd9);
        sweep(DEPTH + 1, 1'b1, "clear_sweep_edges");
        read_all_zero("clear_read_zero");

        // Load entry 20, start a sweep, reset at clr_cnt=10, then a full fresh sweep
        set_in(1'b0, 1'b0, '0, '0, 1'b1, 5'd20, 32'h77777777, 5'd20, 5'd20);
        step();
        wr_off();
        push_exp(K_DR1, 32'h77777777, "load20");
        step();
        bus_a.clear_req = 1'b1; bus_b.clear_req = 1'b1;
        step();
        wr_off();
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        push_exp(K_BUSY, 32'h1, "midrst_busy");
        push_exp(K_CONF, 32'h0, "midrst_conf");
        step();
        rst_n = 1'b1;
        push_exp(K_DR1, 32'h0, "midrst_read_busy");
        sweep(DEPTH, 1'b0, "midrst_sweep_edges");
        read_all_zero("midrst_read_zero");

        step();
        if (n_pass != n_total) begin
            $display("FAIL summary: %0d of %0d checks failed", n_total - n_pass, n_total);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
